// File: rtl/regfile_wb_pkg.sv
// Shared constants for the register-file writeback arbiter: requester indices,
// default widths and the aging threshold.
package regfile_wb_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_MEM  = 2'd0;
    localparam logic [1:0] REQ_ALU  = 2'd1;
    localparam logic [1:0] REQ_MDU  = 2'd2;
    localparam logic [1:0] REQ_NONE = 2'd3;

    localparam int WB_DATA_W    = 64;
    localparam int WB_ADDR_W    = 5;
    localparam int WB_AGE_LIMIT = 4;

    // Lowest set index wins, which is the base order MEM > ALU > MDU.
    function automatic logic [1:0] first_set(input logic [NUM_REQ-1:0] m);
        first_set = REQ_NONE;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (m[i]) first_set = 2'(i);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester handshakes and register-file write port of the writeback arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              mem_vld, alu_vld, mdu_vld;
    logic [ADDR_W-1:0] mem_addr, alu_addr, mdu_addr;
    logic [DATA_W-1:0] mem_data, alu_data, mdu_data;
    logic              mem_rdy, alu_rdy, mdu_rdy;
    logic              D_En;
    logic [ADDR_W-1:0] D_Addr;
    logic [DATA_W-1:0] D;
    logic [1:0]        grant_id;
    logic [2:0]        starved;

    modport master (
        output mem_vld, alu_vld, mdu_vld, mem_addr, alu_addr, mdu_addr,
               mem_data, alu_data, mdu_data,
        input  mem_rdy, alu_rdy, mdu_rdy, D_En, D_Addr, D, grant_id, starved
    );

    modport slave (
        input  mem_vld, alu_vld, mdu_vld, mem_addr, alu_addr, mdu_addr,
               mem_data, alu_data, mdu_data,
        output mem_rdy, alu_rdy, mdu_rdy, D_En, D_Addr, D, grant_id, starved
    );
endinterface

// File: rtl/wb_age_counter.sv
// Per-requester wait counter: counts cycles spent waiting with vld high,
// saturates at AGE_LIMIT and flags the requester as aged there.
module wb_age_counter
    import regfile_wb_pkg::*;
#(
    parameter int AGE_LIMIT = WB_AGE_LIMIT,
    parameter int AGE_W     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic vld,
    input  logic grant,
    output logic aged
);
    logic [AGE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold) begin
            if (grant || !vld)
                cnt_d = '0;
            else if (cnt_q != AGE_W'(AGE_LIMIT))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign aged = (cnt_q == AGE_W'(AGE_LIMIT));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates MEM/ALU/MDU writebacks onto the single register-file write port,
// aged requesters first, and registers the winner for one cycle.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int AGE_LIMIT = WB_AGE_LIMIT,
    parameter int AGE_W     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    regfile_wb_arbiter_if.slave wb
);
    logic [NUM_REQ-1:0]             vld, rdy, aged;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] data;
    logic [1:0]                     sel;

    assign vld  = {wb.mdu_vld, wb.alu_vld, wb.mem_vld};
    assign addr = {wb.mdu_addr, wb.alu_addr, wb.mem_addr};
    assign data = {wb.mdu_data, wb.alu_data, wb.mem_data};

    // Aged requesters pre-empt everyone; base order breaks ties in both tiers.
    always_comb begin
        sel = REQ_NONE;
        rdy = '0;
        if (reset && !hold) begin
            if (|(vld & aged)) sel = first_set(vld & aged);
            else               sel = first_set(vld);
        end
        for (int i = 0; i < NUM_REQ; i++)
            rdy[i] = (sel == 2'(i));
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        wb_age_counter #(.AGE_LIMIT(AGE_LIMIT), .AGE_W(AGE_W)) u_age (
            .clk   (clk),
            .reset (reset),
            .hold  (hold),
            .vld   (vld[i]),
            .grant (rdy[i]),
            .aged  (aged[i])
        );
    end

    logic              d_en_q, d_en_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [1:0]        grant_id_q, grant_id_d;

    // R0 requests are accepted but never raise the write enable.
    always_comb begin
        d_en_d     = 1'b0;
        d_addr_d   = d_addr_q;
        d_d        = d_q;
        grant_id_d = sel;
        if (sel != REQ_NONE) begin
            d_en_d   = (addr[sel] != '0);
            d_addr_d = addr[sel];
            d_d      = data[sel];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_en_q     <= 1'b0;
            d_addr_q   <= '0;
            d_q        <= '0;
            grant_id_q <= REQ_NONE;
        end else begin
            d_en_q     <= d_en_d;
            d_addr_q   <= d_addr_d;
            d_q        <= d_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wb.mem_rdy  = rdy[0];
    assign wb.alu_rdy  = rdy[1];
    assign wb.mdu_rdy  = rdy[2];
    assign wb.D_En     = d_en_q;
    assign wb.D_Addr   = d_addr_q;
    assign wb.D        = d_q;
    assign wb.grant_id = grant_id_q;
    assign wb.starved  = aged;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-level model.
module tb_regfile_wb_arbiter;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5)) wb ();

    regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .AGE_LIMIT(LIM), .AGE_W(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .hold  (hold),
        .wb    (wb)
    );

    // Observed register file contents, to check what actually got written.
    logic [63:0] rf [32];
    bit   [31:0] wr_seen;
    always @(posedge clk)
        if (wb.D_En) begin
            rf[wb.D_Addr]      <= wb.D;
            wr_seen[wb.D_Addr] <= 1'b1;
        end

    typedef struct {
        bit         rst_first;
        bit         hold;
        logic [2:0] vld;
        logic [2:0] rdy;
        logic [2:0] starved;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic req(input int i, input bit v, input logic [4:0] a, input logic [63:0] d);
        case (i)
            0: begin wb.mem_vld = v; wb.mem_addr = a; wb.mem_data = d; end
            1: begin wb.alu_vld = v; wb.alu_addr = a; wb.alu_data = d; end
            default: begin wb.mdu_vld = v; wb.mdu_addr = a; wb.mdu_data = d; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) req(i, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold  = 1'b0;
        idle_all();
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [2:0] rdy_vec();
        return {wb.mdu_rdy, wb.alu_rdy, wb.mem_rdy};
    endfunction

    // Reference model state for the random phase.
    int          cnt[3];
    bit          pend[3];
    logic [4:0]  pa[3];
    logic [63:0] pd[3];
    int          win, exp_gid;
    bit          exp_den;
    logic [4:0]  exp_a;
    logic [63:0] exp_d;
    logic [2:0]  exp_rdy, exp_st;

    initial begin
        idle_all();
        // Contention from reset: MEM x4, then the aged ALU and MDU, then MEM.
        tbl[0]  = '{1, 0, 3'b111, 3'b001, 3'b000, 2'd3};
        tbl[1]  = '{0, 0, 3'b111, 3'b001, 3'b000, 2'd0};
        tbl[2]  = '{0, 0, 3'b111, 3'b001, 3'b000, 2'd0};
        tbl[3]  = '{0, 0, 3'b111, 3'b001, 3'b000, 2'd0};
        tbl[4]  = '{0, 0, 3'b111, 3'b010, 3'b110, 2'd0};
        tbl[5]  = '{0, 0, 3'b111, 3'b100, 3'b100, 2'd1};
        tbl[6]  = '{0, 0, 3'b111, 3'b001, 3'b000, 2'd2};
        // Same build-up, then 3 cycles of hold exactly when ALU/MDU become aged.
        tbl[7]  = '{1, 0, 3'b111, 3'b001, 3'b000, 2'd3};
        tbl[8]  = '{0, 0, 3'b111, 3'b001, 3'b000, 2'd0};
        tbl[9]  = '{0, 0, 3'b111, 3'b001, 3'b000, 2'd0};
        tbl[10] = '{0, 0, 3'b111, 3'b001, 3'b000, 2'd0};
        tbl[11] = '{0, 1, 3'b111, 3'b000, 3'b110, 2'd0};
        tbl[12] = '{0, 1, 3'b111, 3'b000, 3'b110, 2'd3};
        tbl[13] = '{0, 1, 3'b111, 3'b000, 3'b110, 2'd3};
        tbl[14] = '{0, 0, 3'b111, 3'b010, 3'b110, 2'd3};
        tbl[15] = '{0, 0, 3'b111, 3'b100, 3'b100, 2'd1};

        do_reset();
        chk("reset_den", wb.D_En, 0);
        chk("reset_addr", wb.D_Addr, 0);
        chk("reset_data", wb.D, 0);
        chk("reset_gid", wb.grant_id, 3);
        chk("reset_starved", wb.starved, 0);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst_first) do_reset();
            hold = tbl[i].hold;
            for (int r = 0; r < 3; r++)
                req(r, tbl[i].vld[r], 5'(r + 1), 64'h100 + 64'(r));
            #4;
            chk($sformatf("tbl%0d_rdy", i), rdy_vec(), tbl[i].rdy);
            chk($sformatf("tbl%0d_starved", i), wb.starved, tbl[i].starved);
            chk($sformatf("tbl%0d_gid", i), wb.grant_id, tbl[i].gid);
            chk($sformatf("tbl%0d_den", i), wb.D_En, tbl[i].gid != 2'd3);
            if (tbl[i].gid != 2'd3) begin
                chk($sformatf("tbl%0d_daddr", i), wb.D_Addr, 64'(tbl[i].gid) + 1);
                chk($sformatf("tbl%0d_d", i), wb.D, 64'h100 + 64'(tbl[i].gid));
            end
            step();
        end

        // Single ALU request.
        do_reset();
        req(1, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF);
        #4;
        chk("single_rdy", rdy_vec(), 3'b010);
        step();
        idle_all();
        #4;
        chk("single_den", wb.D_En, 1);
        chk("single_daddr", wb.D_Addr, 5);
        chk("single_d", wb.D, 64'h0123_4567_89AB_CDEF);
        chk("single_gid", wb.grant_id, 1);
        step();

        // R0 write is accepted but never enabled.
        req(0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        #4;
        chk("r0_rdy", rdy_vec(), 3'b001);
        step();
        idle_all();
        #4;
        chk("r0_den", wb.D_En, 0);
        chk("r0_gid", wb.grant_id, 0);
        step();

        // Same-register collision: MEM first, ALU second, ALU's data survives.
        req(0, 1'b1, 5'd7, 64'hAA);
        req(1, 1'b1, 5'd7, 64'hBB);
        #4;
        chk("coll_rdy0", rdy_vec(), 3'b001);
        step();
        req(0, 1'b0, 5'd0, 64'd0);
        #4;
        chk("coll_rdy1", rdy_vec(), 3'b010);
        chk("coll_d0", wb.D, 64'hAA);
        chk("coll_daddr0", wb.D_Addr, 7);
        step();
        idle_all();
        #4;
        chk("coll_d1", wb.D, 64'hBB);
        chk("coll_gid1", wb.grant_id, 1);
        step();
        #4;
        chk("coll_r7", rf[7], 64'hBB);
        step();

        // Reset in the cycle after a grant to R9: that write must be dropped.
        req(0, 1'b1, 5'd9, 64'h99);
        #4;
        chk("rst_rdy", rdy_vec(), 3'b001);
        step();
        idle_all();
        rst_n = 1'b0;
        #1;
        chk("rst_den", wb.D_En, 0);
        chk("rst_gid", wb.grant_id, 3);
        chk("rst_starved", wb.starved, 0);
        step();
        rst_n = 1'b1;
        req(1, 1'b1, 5'd4, 64'h44);
        #4;
        chk("rst_after_rdy", rdy_vec(), 3'b010);
        chk("rst_r9_unwritten", wr_seen[9], 0);
        step();
        idle_all();
        #4;
        chk("rst_after_den", wb.D_En, 1);
        chk("rst_after_daddr", wb.D_Addr, 4);
        chk("rst_after_d", wb.D, 64'h44);
        chk("rst_after_gid", wb.grant_id, 1);
        step();

        // Random traffic; requesters keep their request until accepted.
        do_reset();
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; pend[i] = 0; end
        exp_gid = 3;
        exp_den = 0;
        exp_a   = '0;
        exp_d   = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i] = 1;
                    pa[i]   = 5'($urandom_range(0, 31));
                    pd[i]   = {$urandom, $urandom};
                end
                req(i, pend[i], pend[i] ? pa[i] : 5'd0, pend[i] ? pd[i] : 64'd0);
            end
            hold = ($urandom_range(0, 9) == 0);

            win = -1;
            if (!hold) begin
                for (int i = 0; i < 3; i++)
                    if (win < 0 && pend[i] && cnt[i] == LIM) win = i;
                for (int i = 0; i < 3; i++)
                    if (win < 0 && pend[i]) win = i;
            end
            exp_rdy = '0;
            exp_st  = '0;
            for (int i = 0; i < 3; i++) begin
                exp_rdy[i] = (win == i);
                exp_st[i]  = (cnt[i] == LIM);
            end

            #4;
            chk("rnd_rdy", rdy_vec(), exp_rdy);
            chk("rnd_starved", wb.starved, exp_st);
            chk("rnd_gid", wb.grant_id, 64'(exp_gid));
            chk("rnd_den", wb.D_En, exp_den);
            if (exp_den) begin
                chk("rnd_daddr", wb.D_Addr, exp_a);
                chk("rnd_d", wb.D, exp_d);
            end
            step();

            if (!hold)
                for (int i = 0; i < 3; i++)
                    cnt[i] = (win == i || !pend[i]) ? 0 : (cnt[i] < LIM ? cnt[i] + 1 : LIM);
            exp_gid = (win < 0) ? 3 : win;
            exp_den = 0;
            if (win >= 0) begin
                exp_den   = (pa[win] != 0);
                exp_a     = pa[win];
                exp_d     = pd[win];
                pend[win] = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
